// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax row scheduler and row engine:
// pass codes, scheduler state encoding and width-derivation helpers.
package softmax_pkg;

   localparam logic [1:0] PH_MAX  = 2'd0;
   localparam logic [1:0] PH_SUM  = 2'd1;
   localparam logic [1:0] PH_NORM = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } sched_state_t;

   function automatic int unsigned clog2_f(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 32'd1;
      end
      return r;
   endfunction

   // A counter for a single value still needs one bit of storage.
   function automatic int unsigned width_f(input int unsigned v);
      return (clog2_f(v) == 0) ? 32'd1 : clog2_f(v);
   endfunction

   function automatic int unsigned addr_w_f(input int unsigned m, input int unsigned s1,
                                            input int unsigned s2);
      return width_f(m * s1 * s2);
   endfunction

   function automatic int unsigned row_w_f(input int unsigned m, input int unsigned s1);
      return width_f(m * s1);
   endfunction

endpackage

// File: rtl/softmax_row_scheduler.sv
// Walks every row of every matrix through the shared softmax engine,
// issuing MAX, SUM and NORM passes with per-beat element addresses.
module softmax_row_scheduler
   import softmax_pkg::*;
#(
   parameter int unsigned MATRIX_NUM    = 12,
   parameter int unsigned INPUT_SHAPE_1 = 128,
   parameter int unsigned INPUT_SHAPE_2 = 128,
   parameter int unsigned LANES         = 16,
   parameter int unsigned ADDR_W        = addr_w_f(MATRIX_NUM, INPUT_SHAPE_1, INPUT_SHAPE_2),
   parameter int unsigned ROW_W         = row_w_f(MATRIX_NUM, INPUT_SHAPE_1)
) (
   input  logic              clk_p,
   input  logic              rst_p,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              eng_vld,
   input  logic              eng_rdy,
   output logic [1:0]        eng_phase,
   output logic              eng_first,
   output logic              eng_last,
   output logic [ADDR_W-1:0] eng_addr,
   output logic [ROW_W-1:0]  eng_row,
   input  logic              eng_pass_done
);

   localparam int unsigned BEATS  = INPUT_SHAPE_2 / LANES;
   localparam int unsigned BEAT_W = width_f(BEATS);
   localparam int unsigned MAT_W  = width_f(MATRIX_NUM);
   localparam int unsigned RIN_W  = width_f(INPUT_SHAPE_1);

   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
   localparam logic [MAT_W-1:0]  MAT_LAST  = MAT_W'(MATRIX_NUM - 1);
   localparam logic [RIN_W-1:0]  RIN_LAST  = RIN_W'(INPUT_SHAPE_1 - 1);
   localparam logic [ADDR_W-1:0] BEAT_STEP = ADDR_W'(LANES);
   localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(INPUT_SHAPE_2);

   sched_state_t      state_q, state_d;
   logic [1:0]        phase_q, phase_d;
   logic [BEAT_W-1:0] beat_q,  beat_d;
   logic [MAT_W-1:0]  mat_q,   mat_d;
   logic [RIN_W-1:0]  rin_q,   rin_d;
   logic [ROW_W-1:0]  row_q,   row_d;
   logic [ADDR_W-1:0] base_q,  base_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;

   logic last_beat;
   logic last_row;

   assign last_beat = (beat_q == BEAT_LAST);
   assign last_row  = (mat_q == MAT_LAST) && (rin_q == RIN_LAST);

   always_ff @(posedge clk_p) begin
      if (rst_p) begin
         state_q <= ST_IDLE;
         phase_q <= PH_MAX;
         beat_q  <= '0;
         mat_q   <= '0;
         rin_q   <= '0;
         row_q   <= '0;
         base_q  <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         beat_q  <= beat_d;
         mat_q   <= mat_d;
         rin_q   <= rin_d;
         row_q   <= row_d;
         base_q  <= base_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      beat_d  = beat_q;
      mat_d   = mat_q;
      rin_d   = rin_q;
      row_d   = row_q;
      base_d  = base_q;
      addr_d  = addr_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_ISSUE;
               phase_d = PH_MAX;
               beat_d  = '0;
               mat_d   = '0;
               rin_d   = '0;
               row_d   = '0;
               base_d  = '0;
               addr_d  = '0;
            end
         end

         ST_ISSUE: begin
            if (eng_rdy) begin
               if (last_beat) begin
                  // Rewind to the row base so the next pass rereads the same row.
                  state_d = ST_WAIT;
                  beat_d  = '0;
                  addr_d  = base_q;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
                  addr_d = addr_q + BEAT_STEP;
               end
            end
         end

         ST_WAIT: begin
            if (eng_pass_done) begin
               unique case (phase_q)
                  PH_MAX: begin
                     phase_d = PH_SUM;
                     state_d = ST_ISSUE;
                  end
                  PH_SUM: begin
                     phase_d = PH_NORM;
                     state_d = ST_ISSUE;
                  end
                  default: begin
                     if (last_row) begin
                        // Clear the walk so the completion cycle shows an idle bus.
                        state_d = ST_DONE;
                        phase_d = PH_MAX;
                        mat_d   = '0;
                        rin_d   = '0;
                        row_d   = '0;
                        base_d  = '0;
                        addr_d  = '0;
                     end else begin
                        state_d = ST_ISSUE;
                        phase_d = PH_MAX;
                        row_d   = row_q + ROW_W'(1);
                        base_d  = base_q + ROW_STEP;
                        addr_d  = base_q + ROW_STEP;
                        if (rin_q == RIN_LAST) begin
                           rin_d = '0;
                           mat_d = mat_q + MAT_W'(1);
                        end else begin
                           rin_d = rin_q + RIN_W'(1);
                        end
                     end
                  end
               endcase
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (abort && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         phase_d = PH_MAX;
         beat_d  = '0;
         mat_d   = '0;
         rin_d   = '0;
         row_d   = '0;
         base_d  = '0;
         addr_d  = '0;
      end
   end

   assign busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
   assign done      = (state_q == ST_DONE);
   assign eng_vld   = (state_q == ST_ISSUE);
   assign eng_phase = phase_q;
   assign eng_first = eng_vld && (beat_q == '0);
   assign eng_last  = eng_vld && last_beat;
   assign eng_addr  = addr_q;
   assign eng_row   = row_q;

endmodule

// File: tb/tb_softmax_row_scheduler.sv
// Directed bench for softmax_row_scheduler: a 2x2x8 tensor (two beats per pass)
// on one instance and a 2x2x4 tensor (one beat per pass) on a second instance.
module tb_softmax_row_scheduler;

   logic clk_p = 1'b0;
   logic rst_p, start, abort, eng_rdy, eng_pass_done, sel;
   logic start_a, start_b;

   logic       busy_a, done_a, vld_a, first_a, last_a;
   logic [1:0] ph_a, row_a;
   logic [4:0] addr_a;
   logic       busy_b, done_b, vld_b, first_b, last_b;
   logic [1:0] ph_b, row_b;
   logic [3:0] addr_b;

   logic       o_busy, o_done, o_vld, o_first, o_last;
   logic [1:0] o_ph, o_row;
   logic [7:0] o_addr;

   int tests = 0;
   int fails = 0;

   int q_ph[$], q_first[$], q_last[$], q_addr[$], q_row[$];
   int n_done, n_stall, stab_err, done_cyc, pd_cyc;
   bit timed_out, vld_first;

   always #5 clk_p = ~clk_p;

   assign start_a = start & ~sel;
   assign start_b = start & sel;

   assign o_busy  = sel ? busy_b  : busy_a;
   assign o_done  = sel ? done_b  : done_a;
   assign o_vld   = sel ? vld_b   : vld_a;
   assign o_first = sel ? first_b : first_a;
   assign o_last  = sel ? last_b  : last_a;
   assign o_ph    = sel ? ph_b    : ph_a;
   assign o_row   = sel ? row_b   : row_a;
   assign o_addr  = sel ? {4'd0, addr_b} : {3'd0, addr_a};

   softmax_row_scheduler #(
      .MATRIX_NUM(2), .INPUT_SHAPE_1(2), .INPUT_SHAPE_2(8), .LANES(4)
   ) dut_a (
      .clk_p(clk_p), .rst_p(rst_p), .start(start_a), .abort(abort),
      .busy(busy_a), .done(done_a), .eng_vld(vld_a), .eng_rdy(eng_rdy),
      .eng_phase(ph_a), .eng_first(first_a), .eng_last(last_a),
      .eng_addr(addr_a), .eng_row(row_a), .eng_pass_done(eng_pass_done)
   );

   softmax_row_scheduler #(
      .MATRIX_NUM(2), .INPUT_SHAPE_1(2), .INPUT_SHAPE_2(4), .LANES(4)
   ) dut_b (
      .clk_p(clk_p), .rst_p(rst_p), .start(start_b), .abort(abort),
      .busy(busy_b), .done(done_b), .eng_vld(vld_b), .eng_rdy(eng_rdy),
      .eng_phase(ph_b), .eng_first(first_b), .eng_last(last_b),
      .eng_addr(addr_b), .eng_row(row_b), .eng_pass_done(eng_pass_done)
   );

   // Job driver: records accepted beats; modes 0 plain, 1 row-1 SUM stall,
   // 2 start/pass_done noise, 3 abort in row-2 NORM wait, 4 reset in row-1 MAX.
   task automatic run_job(input int mode, input int max_cyc);
      int pd_cnt, sidx;
      bit held, fin;
      int h_ph, h_addr, h_row;
      logic [3:0] stall_pat;
      q_ph.delete(); q_first.delete(); q_last.delete(); q_addr.delete(); q_row.delete();
      n_done = 0; n_stall = 0; stab_err = 0; done_cyc = -1; pd_cyc = -1;
      timed_out = 0; vld_first = 0;
      pd_cnt = 0; sidx = 0; held = 0; fin = 0; h_ph = 0; h_addr = 0; h_row = 0;
      stall_pat = 4'b1001;
      @(negedge clk_p);
      start = 1; eng_rdy = 1; eng_pass_done = 0;
      for (int c = 0; c < max_cyc && !fin; c++) begin
         @(negedge clk_p);
         start = (mode == 2);
         eng_pass_done = 0;
         eng_rdy = 1;
         if (c == 0) vld_first = o_vld;
         if (held && (!o_vld || int'(o_ph) != h_ph || int'(o_addr) != h_addr ||
                      int'(o_row) != h_row)) stab_err++;
         if (o_done) begin
            n_done++; done_cyc = c; fin = 1; held = 0;
         end else begin
            if (pd_cnt > 0) begin
               pd_cnt--;
               if (pd_cnt == 0) begin eng_pass_done = 1; pd_cyc = c; end
            end
            if (mode == 2 && o_vld) eng_pass_done = 1;
            if (mode == 1 && o_vld && o_row == 2'd1 && o_ph == 2'd1 && sidx < 4) begin
               eng_rdy = stall_pat[sidx];
               sidx++;
            end
            if (mode == 3 && o_busy && !o_vld && o_row == 2'd2 && o_ph == 2'd2) begin
               abort = 1; eng_pass_done = 1; fin = 1;
            end else if (mode == 4 && o_vld && o_row == 2'd1 && o_ph == 2'd0) begin
               rst_p = 1; fin = 1;
            end else if (o_vld) begin
               held = !eng_rdy;
               h_ph = int'(o_ph); h_addr = int'(o_addr); h_row = int'(o_row);
               if (eng_rdy) begin
                  q_ph.push_back(int'(o_ph)); q_first.push_back(int'(o_first));
                  q_last.push_back(int'(o_last)); q_addr.push_back(int'(o_addr));
                  q_row.push_back(int'(o_row));
                  if (o_last) pd_cnt = 2;
               end else begin
                  n_stall++;
               end
            end else begin
               held = 0;
            end
         end
      end
      if (!fin) timed_out = 1;
   endtask

   task automatic test_reset();
      sel = 0; start = 0; abort = 0; eng_rdy = 0; eng_pass_done = 0; rst_p = 1;
      repeat (2) @(negedge clk_p);
      rst_p = 0;
      tests++;
      if ({busy_a, done_a, vld_a, first_a, last_a, ph_a, row_a, addr_a} !== 14'd0) begin
         fails++; $display("FAIL reset_a: got %b required 0",
                           {busy_a, done_a, vld_a, first_a, last_a, ph_a, row_a, addr_a});
      end
      tests++;
      if ({busy_b, done_b, vld_b, first_b, last_b, ph_b, row_b, addr_b} !== 13'd0) begin
         fails++; $display("FAIL reset_b: got %b required 0",
                           {busy_b, done_b, vld_b, first_b, last_b, ph_b, row_b, addr_b});
      end
      abort = 1;
      @(negedge clk_p);
      abort = 0;
      @(negedge clk_p);
      tests++;
      if (busy_a !== 1'b0 || vld_a !== 1'b0) begin
         fails++; $display("FAIL idle_hold: busy=%b vld=%b required 0 0", busy_a, vld_a);
      end
   endtask

   task automatic test_full_job();
      int i;
      run_job(0, 400);
      tests++;
      if (timed_out) begin fails++; $display("FAIL full_timeout: no done within budget"); end
      tests++;
      if (vld_first !== 1'b1) begin
         fails++; $display("FAIL full_latency: vld=%0d required 1", vld_first);
      end
      i = 0;
      for (int r = 0; r < 4; r++)
         for (int p = 0; p < 3; p++)
            for (int b = 0; b < 2; b++) begin
               tests++;
               if (i >= q_addr.size()) begin
                  fails++; $display("FAIL full_beat%0d: missing, required row %0d ph %0d", i, r, p);
               end else if (q_row[i] != r || q_ph[i] != p || q_addr[i] != r * 8 + b * 4 ||
                            q_first[i] != (b == 0) || q_last[i] != (b == 1)) begin
                  fails++;
                  $display("FAIL full_beat%0d: row %0d ph %0d addr %0d f%0d l%0d required row %0d ph %0d addr %0d f%0d l%0d",
                           i, q_row[i], q_ph[i], q_addr[i], q_first[i], q_last[i],
                           r, p, r * 8 + b * 4, b == 0, b == 1);
               end
               i++;
            end
      tests++;
      if (q_addr.size() != 24) begin
         fails++; $display("FAIL full_count: got %0d beats required 24", q_addr.size());
      end
      tests++;
      if (n_done != 1) begin fails++; $display("FAIL full_done: got %0d required 1", n_done); end
      @(negedge clk_p);
      tests++;
      if (o_busy !== 1'b0 || o_vld !== 1'b0 || o_done !== 1'b0) begin
         fails++; $display("FAIL full_after: busy=%b vld=%b done=%b required 0 0 0",
                           o_busy, o_vld, o_done);
      end
   endtask

   task automatic test_stall();
      int i;
      run_job(1, 400);
      tests++;
      if (timed_out) begin fails++; $display("FAIL stall_timeout: no done within budget"); end
      tests++;
      if (n_stall != 2) begin fails++; $display("FAIL stall_cycles: got %0d required 2", n_stall); end
      tests++;
      if (stab_err != 0) begin
         fails++; $display("FAIL stall_stable: got %0d changes required 0", stab_err);
      end
      i = 0;
      for (int r = 0; r < 4; r++)
         for (int p = 0; p < 3; p++)
            for (int b = 0; b < 2; b++) begin
               tests++;
               if (i >= q_addr.size() || q_row[i] != r || q_ph[i] != p ||
                   q_addr[i] != r * 8 + b * 4 || q_first[i] != (b == 0) || q_last[i] != (b == 1)) begin
                  fails++;
                  $display("FAIL stall_beat%0d: got addr %0d required row %0d ph %0d addr %0d",
                           i, (i < q_addr.size()) ? q_addr[i] : -1, r, p, r * 8 + b * 4);
               end
               i++;
            end
      tests++;
      if (q_addr.size() != 24) begin
         fails++; $display("FAIL stall_count: got %0d beats required 24", q_addr.size());
      end
      @(negedge clk_p);
   endtask

   task automatic test_ignored_inputs();
      int i;
      run_job(2, 400);
      @(negedge clk_p);
      start = 0;
      tests++;
      if (timed_out) begin fails++; $display("FAIL noise_timeout: no done within budget"); end
      tests++;
      if (o_busy !== 1'b0 || o_vld !== 1'b0) begin
         fails++; $display("FAIL noise_restart: busy=%b vld=%b required 0 0", o_busy, o_vld);
      end
      i = 0;
      for (int r = 0; r < 4; r++)
         for (int p = 0; p < 3; p++)
            for (int b = 0; b < 2; b++) begin
               tests++;
               if (i >= q_addr.size() || q_row[i] != r || q_ph[i] != p ||
                   q_addr[i] != r * 8 + b * 4 || q_first[i] != (b == 0) || q_last[i] != (b == 1)) begin
                  fails++;
                  $display("FAIL noise_beat%0d: got addr %0d required row %0d ph %0d addr %0d",
                           i, (i < q_addr.size()) ? q_addr[i] : -1, r, p, r * 8 + b * 4);
               end
               i++;
            end
      tests++;
      if (q_addr.size() != 24 || n_done != 1) begin
         fails++; $display("FAIL noise_count: got %0d beats %0d done required 24 1",
                           q_addr.size(), n_done);
      end
      @(negedge clk_p);
   endtask

   task automatic test_abort();
      run_job(3, 400);
      @(negedge clk_p);
      abort = 0; eng_pass_done = 0;
      tests++;
      if (timed_out) begin fails++; $display("FAIL abort_timeout: abort point not reached"); end
      tests++;
      if ({o_busy, o_done, o_vld, o_first, o_last, o_ph, o_row, o_addr} !== 15'd0) begin
         fails++; $display("FAIL abort_outputs: got %b required 0",
                           {o_busy, o_done, o_vld, o_first, o_last, o_ph, o_row, o_addr});
      end
      tests++;
      if (q_addr.size() != 18) begin
         fails++; $display("FAIL abort_beats: got %0d required 18", q_addr.size());
      end
      @(negedge clk_p);
      tests++;
      if (o_done !== 1'b0 || o_busy !== 1'b0) begin
         fails++; $display("FAIL abort_nodone: done=%b busy=%b required 0 0", o_done, o_busy);
      end
      run_job(0, 400);
      tests++;
      if (q_addr.size() == 0 || q_row[0] != 0 || q_ph[0] != 0 || q_addr[0] != 0) begin
         fails++; $display("FAIL abort_restart: first beat not row 0 MAX addr 0 (%0d beats)",
                           q_addr.size());
      end
      tests++;
      if (q_addr.size() != 24 || n_done != 1) begin
         fails++; $display("FAIL abort_rerun: got %0d beats %0d done required 24 1",
                           q_addr.size(), n_done);
      end
      @(negedge clk_p);
   endtask

   task automatic test_single_beat();
      int i;
      sel = 1;
      run_job(0, 400);
      tests++;
      if (timed_out) begin fails++; $display("FAIL b1_timeout: no done within budget"); end
      i = 0;
      for (int r = 0; r < 4; r++)
         for (int p = 0; p < 3; p++) begin
            tests++;
            if (i >= q_addr.size() || q_row[i] != r || q_ph[i] != p || q_addr[i] != r * 4 ||
                q_first[i] != 1 || q_last[i] != 1) begin
               fails++;
               $display("FAIL b1_beat%0d: got addr %0d required row %0d ph %0d addr %0d first=last=1",
                        i, (i < q_addr.size()) ? q_addr[i] : -1, r, p, r * 4);
            end
            i++;
         end
      tests++;
      if (q_addr.size() != 12) begin
         fails++; $display("FAIL b1_count: got %0d beats required 12", q_addr.size());
      end
      tests++;
      if (n_done != 1 || done_cyc != pd_cyc + 1) begin
         fails++; $display("FAIL b1_done: done at %0d last pass_done at %0d required next cycle",
                           done_cyc, pd_cyc);
      end
      @(negedge clk_p);
      sel = 0;
   endtask

   task automatic test_reset_mid_job();
      run_job(4, 400);
      @(negedge clk_p);
      tests++;
      if (timed_out) begin fails++; $display("FAIL rst_timeout: reset point not reached"); end
      tests++;
      if ({o_busy, o_done, o_vld, o_first, o_last, o_ph, o_row, o_addr} !== 15'd0) begin
         fails++; $display("FAIL rst_outputs: got %b required 0",
                           {o_busy, o_done, o_vld, o_first, o_last, o_ph, o_row, o_addr});
      end
      rst_p = 0;
      tests++;
      if (q_addr.size() != 6) begin
         fails++; $display("FAIL rst_beats: got %0d required 6", q_addr.size());
      end
      @(negedge clk_p);
      tests++;
      if (o_busy !== 1'b0 || o_done !== 1'b0) begin
         fails++; $display("FAIL rst_idle: busy=%b done=%b required 0 0", o_busy, o_done);
      end
   endtask

   initial begin
      test_reset();
      test_full_job();
      test_stall();
      test_ignored_inputs();
      test_abort();
      test_single_beat();
      test_reset_mid_job();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
